modexp_seq_controller: RTL and testbench

Parametrised control FSM for the modular-exponentiation engine, successor to the fixed multiply/modulo sequencer. It scans an EXP_WIDTH-bit exponent with right-to-left square-and-multiply. It issues multiply and modulo requests to a multi-cycle datapath over request/ready handshakes and skips work past the most significant set bit. It also gates DATA requests until both key registers (e, n) are loaded.

---
 rtl/modexp_seq_controller.sv | 176 +++++++++++++++++
 tb/tb_modexp_seq_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_seq_controller.sv
// Sequencing FSM for the modular-exponentiation datapath: right-to-left
// square-and-multiply over EXP_WIDTH exponent bits, with key-load gating.
module modexp_seq_controller #(
    parameter int EXP_WIDTH = 16,
    parameter int IDX_W     = $clog2(EXP_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           input_data_type,
    input  logic [EXP_WIDTH-1:0] e_in,
    input  logic                 init_done,
    input  logic                 mul_ready,
    input  logic                 mod_ready,
    output logic                 initialize,
    output logic                 en_multiply,
    output logic                 mul_sel,
    output logic                 en_modulo,
    output logic                 update_e,
    output logic                 update_n,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [IDX_W-1:0]     bit_idx
);

    localparam logic [2:0] TYPE_DATA = 3'd1;
    localparam logic [2:0] TYPE_E    = 3'd2;
    localparam logic [2:0] TYPE_N    = 3'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_SCAN,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_MOD_REQ,
        S_MOD_WAIT,
        S_DONE,
        S_UPD_E,
        S_UPD_N
    } state_t;

    state_t                 state;
    logic [EXP_WIDTH-1:0]   e_reg;
    logic [EXP_WIDTH-1:0]   ework;
    logic                   e_valid;
    logic                   n_valid;
    logic                   phase;

    // phase 0 = result*base, 1 = base*base; held through the modulo step
    assign mul_sel = phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            e_reg       <= '0;
            ework       <= '0;
            e_valid     <= 1'b0;
            n_valid     <= 1'b0;
            phase       <= 1'b0;
            bit_idx     <= '0;
            initialize  <= 1'b0;
            en_multiply <= 1'b0;
            en_modulo   <= 1'b0;
            update_e    <= 1'b0;
            update_n    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            en_multiply <= 1'b0;
            en_modulo   <= 1'b0;
            update_e    <= 1'b0;
            update_n    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;

            case (state)
                S_IDLE: begin
                    case (input_data_type)
                        TYPE_E: begin
                            e_reg    <= e_in;
                            e_valid  <= 1'b1;
                            update_e <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_UPD_E;
                        end
                        TYPE_N: begin
                            n_valid  <= 1'b1;
                            update_n <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_UPD_N;
                        end
                        TYPE_DATA: begin
                            if (e_valid && n_valid) begin
                                initialize <= 1'b1;
                                busy       <= 1'b1;
                                state      <= S_INIT;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end

                S_UPD_E, S_UPD_N: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                S_INIT: begin
                    if (init_done) begin
                        initialize <= 1'b0;
                        ework      <= e_reg;
                        bit_idx    <= '0;
                        state      <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (ework == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        phase       <= ~ework[0];
                        en_multiply <= 1'b1;
                        state       <= S_MUL_REQ;
                    end
                end

                S_MUL_REQ: state <= S_MUL_WAIT;

                S_MUL_WAIT: begin
                    if (mul_ready) begin
                        en_modulo <= 1'b1;
                        state     <= S_MOD_REQ;
                    end
                end

                S_MOD_REQ: state <= S_MOD_WAIT;

                S_MOD_WAIT: begin
                    if (mod_ready) begin
                        if (!phase) begin
                            // Squaring past the top set bit would be wasted work
                            if (ework[EXP_WIDTH-1:1] == '0) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                phase       <= 1'b1;
                                en_multiply <= 1'b1;
                                state       <= S_MUL_REQ;
                            end
                        end else begin
                            ework   <= ework >> 1;
                            bit_idx <= bit_idx + IDX_W'(1);
                            state   <= S_SCAN;
                        end
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_seq_controller.sv
// Scoreboard bench for modexp_seq_controller: expected events are queued when
// stimulus is driven and matched against DUT output pulses.
module tb_modexp_seq_controller;

    localparam int EW = 16;
    localparam int IW = $clog2(EW);

    logic          clk;
    logic          rst;
    logic [2:0]    input_data_type;
    logic [EW-1:0] e_in;
    logic          init_done;
    logic          mul_ready;
    logic          mod_ready;
    logic          initialize;
    logic          en_multiply;
    logic          mul_sel;
    logic          en_modulo;
    logic          update_e;
    logic          update_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] bit_idx;

    modexp_seq_controller #(.EXP_WIDTH(EW)) dut (
        .clk             (clk),
        .rst             (rst),
        .input_data_type (input_data_type),
        .e_in            (e_in),
        .init_done       (init_done),
        .mul_ready       (mul_ready),
        .mod_ready       (mod_ready),
        .initialize      (initialize),
        .en_multiply     (en_multiply),
        .mul_sel         (mul_sel),
        .en_modulo       (en_modulo),
        .update_e        (update_e),
        .update_n        (update_n),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .bit_idx         (bit_idx)
    );

    typedef struct {
        logic sel;
        int   idx;
    } mul_exp_t;

    typedef struct {
        int cyc;
        int kind;
    } upd_exp_t;

    mul_exp_t mul_q[$];
    upd_exp_t upd_q[$];
    int       done_q[$];
    int       err_q[$];

    int       n_tests = 0;
    int       n_fail  = 0;
    int       cyc     = 0;
    int       mod_cnt = 0;
    int       exp_ops = 0;
    logic [EW-1:0] exp_e = '0;
    logic     last_sel = 1'b0;
    int       mul_extra = 0;
    int       mod_extra = 0;
    logic     hold_rdy = 1'b0;
    mul_exp_t m_pop;
    upd_exp_t u_pop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Multiply responder: ready arrives mul_extra cycles after the first WAIT cycle
    initial begin
        mul_ready = 1'b0;
        forever begin
            tick();
            if (hold_rdy) begin
                mul_ready = 1'b1;
            end else begin
                mul_ready = 1'b0;
                if (en_multiply) begin
                    repeat (mul_extra + 1) @(posedge clk);
                    #1;
                    mul_ready = 1'b1;
                    tick();
                    mul_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        mod_ready = 1'b0;
        forever begin
            tick();
            if (hold_rdy) begin
                mod_ready = 1'b1;
            end else begin
                mod_ready = 1'b0;
                if (en_modulo) begin
                    repeat (mod_extra + 1) @(posedge clk);
                    #1;
                    mod_ready = 1'b1;
                    tick();
                    mod_ready = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end
            if (en_multiply) begin
                if (mul_q.size() == 0) begin
                    check("mul_unexpected", 1, 0);
                end else begin
                    m_pop = mul_q.pop_front();
                    check("mul_sel", int'(mul_sel), int'(m_pop.sel));
                    check("bit_idx", int'(bit_idx), m_pop.idx);
                    last_sel = m_pop.sel;
                end
            end
            if (en_modulo) begin
                mod_cnt++;
                check("mod_sel_held", int'(mul_sel), int'(last_sel));
            end
            if (err) begin
                if (err_q.size() == 0) check("err_unexpected", 1, 0);
                else check("err_cycle", cyc, err_q.pop_front());
            end
            if (update_e || update_n) begin
                if (upd_q.size() == 0) begin
                    check("upd_unexpected", 1, 0);
                end else begin
                    u_pop = upd_q.pop_front();
                    check("upd_cycle", cyc, u_pop.cyc);
                    check("upd_kind", int'({update_n, update_e}), u_pop.kind);
                end
            end
        end
    end

    task automatic load_key(input logic is_e, input logic [EW-1:0] val);
        if (is_e) begin
            e_in            = val;
            exp_e           = val;
            input_data_type = 3'd2;
            upd_q.push_back('{cyc: cyc + 1, kind: 1});
        end else begin
            input_data_type = 3'd3;
            upd_q.push_back('{cyc: cyc + 1, kind: 2});
        end
        tick();
        input_data_type = 3'd0;
        check("key_busy", int'(busy), 1);
        tick();
        check("key_idle", int'(busy), 0);
    endtask

    task automatic send_bad_data();
        input_data_type = 3'd1;
        err_q.push_back(cyc + 1);
        tick();
        input_data_type = 3'd0;
        check("rej_busy", int'(busy), 0);
        check("rej_init", int'(initialize), 0);
        tick();
        check("rej_err_q", err_q.size(), 0);
    endtask

    task automatic start_data(input int mx, input int dx, input int init_dly);
        int t0;
        int msb;
        int pop;
        int n;
        mul_extra       = mx;
        mod_extra       = dx;
        mod_cnt         = 0;
        input_data_type = 3'd1;
        tick();
        input_data_type = 3'd0;
        n = 0;
        while (!initialize && n < 20) begin
            tick();
            n++;
        end
        check("init_level", int'(initialize), 1);
        repeat (init_dly) tick();
        init_done = 1'b1;
        t0  = cyc;
        msb = -1;
        pop = 0;
        for (int i = 0; i < EW; i++) begin
            if (exp_e[i]) begin
                msb = i;
                pop++;
            end
        end
        if (msb < 0) begin
            exp_ops = 0;
            done_q.push_back(t0 + 2);
        end else begin
            for (int i = 0; i <= msb; i++) begin
                if (exp_e[i]) mul_q.push_back('{sel: 1'b0, idx: i});
                if (i < msb) mul_q.push_back('{sel: 1'b1, idx: i});
            end
            exp_ops = pop + msb;
            done_q.push_back(t0 + 1 + (msb + 1) + exp_ops * (4 + mx + dx));
        end
        tick();
        init_done = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done), 1);
        #1;
        check("done_q_left", done_q.size(), 0);
        check("mul_q_left", mul_q.size(), 0);
        check("mod_count", mod_cnt, exp_ops);
        tick();
        check("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b1;
        input_data_type = 3'd0;
        e_in            = '0;
        init_done       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs",
              int'({initialize, en_multiply, mul_sel, en_modulo, update_e,
                    update_n, busy, done, err}), 0);
        check("rst_bit_idx", int'(bit_idx), 0);
        tick();
        rst = 1'b0;
        tick();

        send_bad_data();
        load_key(1'b1, 16'd5);
        send_bad_data();
        load_key(1'b0, '0);

        start_data(0, 0, 0);
        wait_done();

        load_key(1'b1, 16'd0);
        start_data(0, 0, 2);
        wait_done();

        load_key(1'b1, 16'h8001);
        start_data(2, 0, 1);
        wait_done();

        // Readies held high throughout, with a key write attempted mid-operation
        load_key(1'b1, 16'h000B);
        hold_rdy = 1'b1;
        tick();
        tick();
        start_data(0, 0, 1);
        e_in = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            input_data_type = 3'd2;
            @(negedge clk);
            check("busy_midop", int'(busy), 1);
            tick();
        end
        input_data_type = 3'd0;
        wait_done();
        hold_rdy = 1'b0;
        tick();
        tick();
        start_data(1, 1, 0);
        wait_done();

        // Asynchronous reset while waiting on the modulo of the first square
        start_data(0, 30, 0);
        n = 0;
        while (mod_cnt < 2 && n < 500) begin
            tick();
            n++;
        end
        check("mod_req_seen", mod_cnt, 2);
        tick();
        check("pre_rst_sel", int'(mul_sel), 1);
        check("pre_rst_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              int'({initialize, en_multiply, mul_sel, en_modulo, update_e,
                    update_n, busy, done, err}), 0);
        check("async_rst_bit_idx", int'(bit_idx), 0);
        mul_q.delete();
        done_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        send_bad_data();

        repeat (40) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
